pc_fetch_unit: RTL and testbench

//  Program-counter and instruction-fetch stage. Consumes pc_sel and the branch target from the branch controller.

---
 rtl/riscv_fetch_pkg.sv | 15 +
 rtl/pc_next_gen.sv | 22 ++
 rtl/pc_fetch_unit.sv | 122 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared state type and constants for the fetch stage.
// Imported by pc_next_gen and pc_fetch_unit.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/pc_next_gen.sv
// pc_next_gen: next-PC selection between the word-aligned branch target
// and the sequential PC (wraps modulo 2^XLEN).
module pc_next_gen
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_next_o
);

  always_comb begin
    if (pc_sel_i) begin
      pc_next_o = target_i & ~XLEN'(3);
    end else begin
      pc_next_o = pc_i + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction fetch FSM.
// Optional FETCH_MISALIGN_CHECK_EN adds the fetch_misalign output.
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_nxt;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     inst_data_q, inst_data_d;
  logic            inst_valid_q, inst_valid_d;

  pc_next_gen #(.XLEN(XLEN)) u_pc_next (
    .pc_sel_i (pc_sel),
    .pc_i     (pc_q),
    .target_i (branch_target),
    .pc_next_o(pc_nxt)
  );

  // Request is masked while reset is held so nothing leaks out of reset.
  assign imem_req_valid = rst_n & (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    if (pc_sel) begin
      pc_d         = pc_nxt;
      inst_valid_d = 1'b0;
      unique case (state_q)
        REQ:     state_d = imem_req_ready ? KILL : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : KILL;
        HOLD:    state_d = REQ;
        KILL:    state_d = imem_rsp_valid ? REQ : KILL;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst_valid_d = 1'b1;
            inst_data_d  = imem_rsp_data;
            inst_pc_d    = pc_q;
            pc_d         = pc_nxt;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
        KILL: begin
          if (imem_rsp_valid) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
      inst_data_q  <= NOP_INSN;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= pc_sel & (|branch_target[1:0]);
    end
  end

  assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table, hand sequences and a randomized
// run against a behavioural instruction-stream model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  typedef struct {
    logic        rr, rs, ir, sel;
    logic [31:0] tgt, rd;
    logic        e_rv, e_iv;
    logic [31:0] e_addr, e_pc, e_data;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic rr, rs, ir, sel,
                     input logic [31:0] tgt, rd,
                     input logic e_rv, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_pc, e_data);
    vec_t v;
    v.rr = rr; v.rs = rs; v.ir = ir; v.sel = sel;
    v.tgt = tgt; v.rd = rd;
    v.e_rv = e_rv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_pc = e_pc; v.e_data = e_data;
    tv.push_back(v);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state
  logic [31:0] exp_pc, paddr, r;
  logic        pend;
  int          cd, deliv;
  logic        p_req_stall, p_hold_stall, p_mis;
  logic [31:0] p_addr, p_ipc, p_idata;

  initial begin
    rst_n = 1'b0; pc_sel = 1'b0; branch_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0;

    // rr rs ir sel tgt rd | rv addr iv pc data
    add(1,0,0,0, 32'h0,   32'h0,        1, 32'h0,   0, 32'h0, 32'h13);
    add(0,1,0,0, 32'h0,   32'h0050_0093,0, 32'h0,   0, 32'h0, 32'h13);
    for (int i = 0; i < 5; i++)
      add(1,0,0,0, 32'h0, 32'h0,        0, 32'h4,   1, 32'h0, 32'h0050_0093);
    add(1,0,1,0, 32'h0,   32'h0,        0, 32'h4,   1, 32'h0, 32'h0050_0093);
    add(1,0,0,0, 32'h0,   32'h0,        1, 32'h4,   0, 32'h0, 32'h0050_0093);
    add(0,0,0,1, 32'h100, 32'h0,        0, 32'h4,   0, 32'h0, 32'h0050_0093);
    add(0,0,0,0, 32'h0,   32'h0,        0, 32'h100, 0, 32'h0, 32'h0050_0093);
    add(0,1,0,0, 32'h0,   32'hDEAD_BEEF,0, 32'h100, 0, 32'h0, 32'h0050_0093);
    add(1,0,0,0, 32'h0,   32'h0,        1, 32'h100, 0, 32'h0, 32'h0050_0093);
    add(0,1,0,0, 32'h0,   32'h1111_1111,0, 32'h100, 0, 32'h0, 32'h0050_0093);
    add(0,0,1,1, 32'h200, 32'h0,        0, 32'h104, 1, 32'h100, 32'h1111_1111);
    add(0,0,0,0, 32'h0,   32'h0,        1, 32'h200, 0, 32'h100, 32'h1111_1111);
    add(0,0,0,1, 32'hFFFF_FFFC, 32'h0,  1, 32'h200, 0, 32'h100, 32'h1111_1111);
    add(1,0,0,0, 32'h0,   32'h0,        1, 32'hFFFF_FFFC, 0, 32'h100, 32'h1111_1111);
    add(0,1,0,0, 32'h0,   32'h2222_2222,0, 32'hFFFF_FFFC, 0, 32'h100, 32'h1111_1111);
    add(0,0,1,0, 32'h0,   32'h0,        0, 32'h0,   1, 32'hFFFF_FFFC, 32'h2222_2222);
    add(1,0,0,0, 32'h0,   32'h0,        1, 32'h0,   0, 32'hFFFF_FFFC, 32'h2222_2222);
    add(0,1,0,1, 32'h300, 32'h3333_3333,0, 32'h0,   0, 32'hFFFF_FFFC, 32'h2222_2222);
    add(1,0,0,1, 32'h304, 32'h0,        1, 32'h300, 0, 32'hFFFF_FFFC, 32'h2222_2222);
    add(0,1,0,0, 32'h0,   32'h4444_4444,0, 32'h304, 0, 32'hFFFF_FFFC, 32'h2222_2222);
    add(0,0,0,0, 32'h0,   32'h0,        1, 32'h304, 0, 32'hFFFF_FFFC, 32'h2222_2222);

    repeat (2) tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      imem_req_ready = tv[i].rr;
      imem_rsp_valid = tv[i].rs;
      inst_ready     = tv[i].ir;
      pc_sel         = tv[i].sel;
      branch_target  = tv[i].tgt;
      imem_rsp_data  = tv[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tv[i].e_rv});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, tv[i].e_addr);
      chk($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, tv[i].e_iv});
      chk($sformatf("v%0d_inst_pc", i), inst_pc, tv[i].e_pc);
      chk($sformatf("v%0d_inst_data", i), inst_data, tv[i].e_data);
      tick();
    end

    // Reset while a request is outstanding; the late response is ignored.
    imem_rsp_valid = 1'b0; pc_sel = 1'b0; inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    chk("midrst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("midrst_req_valid2", {31'b0, imem_req_valid}, 32'h1);
    chk("midrst_req_addr", imem_req_addr, 32'h0);

    // Misaligned redirect target is aligned down.
    pc_sel = 1'b1; branch_target = 32'h102;
    tick();
    pc_sel = 1'b0; branch_target = '0;
    chk("mis_req_addr", imem_req_addr, 32'h100);
    chk("mis_req_valid", {31'b0, imem_req_valid}, 32'h1);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag_on", {31'b0, fetch_misalign}, 32'h1);
`endif
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag_off", {31'b0, fetch_misalign}, 32'h0);
`endif
    chk("mis_req_addr2", imem_req_addr, 32'h100);

    // Randomized run against the instruction-stream model.
    exp_pc = 32'h100; pend = 1'b0; cd = 0; deliv = 0;
    paddr = '0; p_req_stall = 1'b0; p_hold_stall = 1'b0; p_mis = 1'b0;
    p_addr = '0; p_ipc = '0; p_idata = '0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      pc_sel         = ($urandom_range(0, 11) == 0);
      r = $urandom();
      if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 | {28'b0, r[3:0]};
      else branch_target = {20'b0, r[11:0]};
      imem_rsp_valid = pend && (cd == 0);
      imem_rsp_data  = memw(paddr);
      if (pend && cd != 0) cd--;
      @(negedge clk);
      if (p_req_stall) begin
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("stall_req_addr", imem_req_addr, p_addr);
      end
      if (p_hold_stall) begin
        chk("hold_valid", {31'b0, inst_valid}, 32'h1);
        chk("hold_pc", inst_pc, p_ipc);
        chk("hold_data", inst_data, p_idata);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rnd_misalign", {31'b0, fetch_misalign}, {31'b0, p_mis});
`endif
      p_mis = pc_sel & (|branch_target[1:0]);
      if (imem_rsp_valid) pend = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        if (pend) chk("one_outstanding", 32'h1, 32'h0);
        if (!pc_sel) chk("rnd_req_addr", imem_req_addr, exp_pc);
        pend = 1'b1; paddr = imem_req_addr; cd = $urandom_range(0, 3);
      end
      if (pc_sel) begin
        exp_pc = branch_target & 32'hFFFF_FFFC;
      end else if (inst_valid && inst_ready) begin
        chk("rnd_inst_pc", inst_pc, exp_pc);
        chk("rnd_inst_data", inst_data, memw(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliv++;
      end
      p_req_stall  = imem_req_valid && !imem_req_ready && !pc_sel;
      p_addr       = imem_req_addr;
      p_hold_stall = inst_valid && !inst_ready && !pc_sel;
      p_ipc        = inst_pc;
      p_idata      = inst_data;
      tick();
    end
    chk("rnd_progress", {31'b0, deliv >= 100}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
